// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous data memory.
// Latency: request sampled at E0 -> ack pulse after E2 (3 cycles per access).
// Backpressure: one access in flight; other requester waits in IDLE. Optional macro DMEM_ARB_FIXED_PRIO_EN gives port A strict priority.
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_b;
    logic                r_last_b;
    logic                r_ack_a;
    logic                r_ack_b;
    logic [DATA_W-1:0]   r_rdata_a;
    logic [DATA_W-1:0]   r_rdata_b;
    logic                r_mem_write;
    logic                r_mem_read;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_busy;

    logic                w_grant_vld;
    logic                w_sel_b;
    logic                w_sel_we;

    // A request arriving while an ack is on the wire belongs to the access just finished.
    assign w_grant_vld = (req_a | req_b) & ~r_ack_a & ~r_ack_b;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port A always wins; B only when A is not asking.
    assign w_sel_b = req_b & ~req_a;
`else
    // Round-robin: on contention pick the port that did not win last time.
    assign w_sel_b = req_b & (~req_a | ~r_last_b);
`endif

    assign w_sel_we = w_sel_b ? we_b : we_a;

    // Sequencer: IDLE grants and launches, ACCESS lets memory sample, DONE returns data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_b   <= 1'b0;
            r_last_b    <= 1'b1;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner_b   <= w_sel_b;
                        r_last_b    <= w_sel_b;
                        r_mem_addr  <= w_sel_b ? addr_b : addr_a;
                        r_mem_wdata <= w_sel_b ? wdata_b : wdata_a;
                        r_mem_write <= w_sel_we;
                        r_mem_read  <= ~w_sel_we;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Memory has sampled the strobes at this edge; address/data hold.
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (r_owner_b) begin
                        r_rdata_b <= mem_rdata;
                        r_ack_b   <= 1'b1;
                    end else begin
                        r_rdata_a <= mem_rdata;
                        r_ack_a   <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_a     = r_ack_a;
    assign ack_b     = r_ack_b;
    assign rdata_a   = r_rdata_a;
    assign rdata_b   = r_rdata_b;
    assign mem_write = r_mem_write;
    assign mem_read  = r_mem_read;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a read-before-write memory model.
// Cycle-exact checks sampled on the falling edge.
// Contention section follows DMEM_ARB_FIXED_PRIO_EN when defined.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              ack_a, ack_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              mem_write, mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    logic              pl_en;
    logic [15:0]       pl_addr;
    logic [DATA_W-1:0] pl_dat;
    logic [DATA_W-1:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .ack_a     (ack_a),
        .rdata_a   (rdata_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .ack_b     (ack_b),
        .rdata_b   (rdata_b),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory, read-before-write, decodes address [15:0].
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        if (mem_write | mem_read) mem_rdata <= mem[mem_addr[15:0]];
        if (mem_write) mem[mem_addr[15:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [DATA_W-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_dat  = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Caller is at a falling edge; request is presented immediately.
    task automatic do_access(input bit pb, input bit we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp,
                             input bit keep, input string tag);
        if (pb) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
        @(negedge clk);
        chk({tag, ".wr"},   {63'd0, mem_write}, {63'd0, we});
        chk({tag, ".rd"},   {63'd0, mem_read},  {63'd0, ~we});
        chk({tag, ".addr"}, {32'd0, mem_addr},  {32'd0, addr});
        chk({tag, ".busy1"}, {63'd0, busy}, 64'd1);
        if (we) chk({tag, ".wdat"}, {32'd0, mem_wdata}, {32'd0, wd});
        @(negedge clk);
        chk({tag, ".strb0"}, {62'd0, mem_write, mem_read}, 64'd0);
        chk({tag, ".busy2"}, {63'd0, busy}, 64'd1);
        chk({tag, ".noack"}, {62'd0, ack_a, ack_b}, 64'd0);
        @(negedge clk);
        chk({tag, ".ack"}, {62'd0, ack_a, ack_b}, pb ? 64'd1 : 64'd2);
        chk({tag, ".rdata"}, {32'd0, pb ? rdata_b : rdata_a}, {32'd0, exp});
        chk({tag, ".busy0"}, {63'd0, busy}, 64'd0);
        if (!keep) begin
            req_a = 1'b0; req_b = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".post"}, {59'd0, ack_a, ack_b, busy, mem_read, mem_write}, 64'd0);
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h50; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0;    wdata_b = '0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;

        // Preload while reset is held with req_a asserted.
        @(negedge clk);
        preload(16'h0050, 32'h0000_0077);
        preload(16'h0010, 32'h0000_0000);
        preload(16'h0020, 32'h1111_1111);
        preload(16'h0030, 32'h2222_2222);
        preload(16'h0040, 32'h0000_0005);
        preload(16'h0060, 32'h0000_1234);
        chk("rst.outs", {ack_a, ack_b, mem_write, mem_read, busy}, 64'd0);
        chk("rst.addr", {32'd0, mem_addr}, 64'd0);
        chk("rst.wdat", {32'd0, mem_wdata}, 64'd0);
        chk("rst.rdat", {rdata_a, rdata_b}, 64'd0);

        // First access after reset release.
        rst_n = 1'b1;
        do_access(1'b0, 1'b0, 32'h50, 32'h0, 32'h77, 1'b0, "first");

        // Write then read on A; the read keeps req high through ack to show it is not re-served.
        do_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "wrA");
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, "rdA");
        // Upper address bits pass through unchanged and alias in memory.
        do_access(1'b0, 1'b0, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "alias");

        // Swap on B: old contents returned.
        do_access(1'b1, 1'b1, 32'h40, 32'h9, 32'h5, 1'b0, "swapB");

        // Contention with both ports held.
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h20;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h30;
        for (int n = 1; n <= 16; n++) begin
            logic ea, eb;
            @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            ea = (n == 3) || (n == 7) || (n == 11);
            eb = (n == 15);
`else
            ea = (n == 3) || (n == 11);
            eb = (n == 7) || (n == 15);
`endif
            chk($sformatf("cont.ack%0d", n), {62'd0, ack_a, ack_b}, {62'd0, ea, eb});
            if (ea) chk($sformatf("cont.rda%0d", n), {32'd0, rdata_a}, 64'h1111_1111);
            if (eb) begin
                chk($sformatf("cont.rdb%0d", n), {32'd0, rdata_b}, 64'h2222_2222);
                chk($sformatf("cont.holdA%0d", n), {32'd0, rdata_a}, 64'h1111_1111);
            end
`ifdef DMEM_ARB_FIXED_PRIO_EN
            if (n == 11) req_a = 1'b0;
            if (n == 15) req_b = 1'b0;
`else
            if (n == 15) begin
                req_a = 1'b0; req_b = 1'b0;
            end
`endif
        end
        @(negedge clk);
        chk("cont.idle", {ack_a, ack_b, busy}, 64'd0);

        // A sees the value B swapped in.
        do_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h9, 1'b0, "rd40");

        // Reset during ACCESS: strobe drops asynchronously, no ack, write never lands.
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h60; wdata_a = 32'hAA;
        @(negedge clk);
        chk("mid.wr1", {63'd0, mem_write}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.wr0", {63'd0, mem_write}, 64'd0);
        chk("mid.busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("mid.noack", {62'd0, ack_a, ack_b}, 64'd0);
        rst_n = 1'b1;
        do_access(1'b0, 1'b1, 32'h60, 32'hAA, 32'h1234, 1'b0, "reiss");
        do_access(1'b0, 1'b0, 32'h60, 32'h0, 32'hAA, 1'b0, "rd60");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port synchronous DataMemory.
- Port A is the CPU load/store stage; port B is the secondary master (loader/debug).
- Grants one access at a time, drives the memory's write/read strobes, address and write data from registers, then returns read data with a one-cycle ack pulse.
- Default policy is round-robin.

Parameters:
- ADDR_W, 32, address width; passed unmodified to memory (memory decodes [15:0], so upper bits alias).
- DATA_W, 32, data width of requester and memory data buses.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  port A request; held with we_a/addr_a/wdata_a stable until ack_a.
- we_a  input  1  port A: 1=write, 0=read.
- addr_a  input  ADDR_W  port A address.
- wdata_a  input  DATA_W  port A write data.
- ack_a  output  1  one-cycle completion pulse to port A.
- rdata_a  output  DATA_W  port A read data, valid when ack_a=1, held until next ack_a.
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as port A, for port B.
- mem_write  output  1  to memory write_signal.
- mem_read  output  1  to memory read_signal.
- mem_addr  output  ADDR_W  to memory address.
- mem_wdata  output  DATA_W  to memory dataIn.
- mem_rdata  input  DATA_W  from memory dataOut.
- busy  output  1  high in ACCESS and DONE states.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=B, so A wins the first contention.
  - mem_write, mem_read, mem_addr, mem_wdata, ack_a, ack_b, rdata_a, rdata_b, busy all 0.
- Reset asserted mid-access: the in-flight access is abandoned with no ack; the requester must reissue after reset.
- FSM states IDLE, ACCESS, DONE; all outputs registered.
- IDLE:
  - No req: stay; mem strobes 0.
  - One req: grant it.
  - Both req: grant the port that is not last_grant.
  - On grant, at the same edge:
    - latch owner;
    - mem_addr=addr_x, mem_wdata=wdata_x;
    - mem_write=we_x, mem_read=~we_x;
    - last_grant=x;
    - go ACCESS.
- ACCESS (exactly 1 cycle):
  - Memory samples strobes/address at the closing edge.
  - At that edge: mem_write=0, mem_read=0; mem_addr/mem_wdata hold; go DONE.
- DONE (exactly 1 cycle):
  - mem_rdata is valid.
  - At the closing edge: rdata_owner=mem_rdata, ack_owner=1 for the following cycle; go IDLE.
  - ack is therefore high during the first IDLE cycle.
  - The non-owner's rdata and ack are unchanged.
- Requester rule: drop req (or present a new request) at the edge where ack is seen.
  - The arbiter ignores req during the cycle ack is high, so an unchanged req is not double-served.
  - The next grant is evaluated at the following edge.
- Latency: req sampled at edge E0 -> ack high after E2, i.e. 3 cycles per access. Back-to-back throughput is one access per 4 cycles per port.
- Write ack: rdata_x returns the pre-write contents of the address (memory is read-before-write). This is usable as an atomic swap.
- Read ack: rdata_x = memory contents at the address.
- Fairness: with continuous requests on both ports, grants alternate A,B,A,B.
- req dropped during ACCESS/DONE: the access still completes and ack is still pulsed; owner inputs are not resampled after grant.
- Non-owner inputs are ignored until IDLE.
- Address/data widths pass straight through; no arithmetic.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins contention. last_grant is still updated but not used for selection. B is served only when req_a=0 in the IDLE evaluation cycle.
- Undefined: round-robin as above.

Test Plan:
- Reset: hold rst_n=0 while req_a=1 -> all outputs 0, no ack. Release rst_n -> first ack_a 3 cycles after the first sampled req.
- Write then read on A: write addr 0x10 data 0xDEADBEEF -> ack_a with rdata_a = previous contents (0 after preload). Then read 0x10 -> ack_a with rdata_a=0xDEADBEEF, mem_read high exactly one cycle.
- Contention: req_a and req_b both held continuously, A reads 0x20, B reads 0x30 (preloaded 0x11111111/0x22222222) -> order A,B,A,B. Each ack 4 cycles apart, rdata_b=0x22222222 with ack_b only.
- Swap on B: preload 0x40=0x5, B writes 0x9 to 0x40 -> rdata_b=0x5; a subsequent A read of 0x40 -> 0x9.
- Reset mid-ACCESS: assert rst_n=0 while mem_write=1 -> mem_write drops immediately (async), no ack_a. After release, reissue -> normal completion.
- With DMEM_ARB_FIXED_PRIO_EN: both ports requesting continuously -> only A is acked until req_a drops; B is acked 3 cycles after that.
